// File: rtl/divide_restoring_param_pkg.sv
// Shared definitions for the parametrised restoring divider:
// FSM state type, default widths and the divide-by-zero quotient constant.
package divide_pkg;

   // Controller states: waiting, iterating, result held
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DEF_DIVIDEND_W = 32;
   localparam int DEF_DIVISOR_W  = 16;

   // Widest dividend the divide-by-zero constant helper can describe
   localparam int DIV_MAX_W = 128;

   // Quotient reported for a zero divisor: all ones across the low w bits
   function automatic logic [DIV_MAX_W-1:0] div0_quotient(input int w);
      div0_quotient = ~({DIV_MAX_W{1'b1}} << w);
   endfunction

endpackage

// File: rtl/divide_restoring_param_if.sv
// Request/result bundle between the integer ALU multi-cycle port (master)
// and the restoring divider (slave).
interface divide_restoring_param_if
   import divide_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
);
   localparam int CNT_W = $clog2(DIVIDEND_W);

   logic                  start;
   logic                  signed_op;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  busy;
   logic                  ready;
   logic                  div0;
   logic [CNT_W-1:0]      count;

   modport master (
      output start, signed_op, dividend, divisor,
      input  quotient, remainder, busy, ready, div0, count
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output quotient, remainder, busy, ready, div0, count
   );

endinterface

// File: rtl/divide_restoring_param_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and either keep
// the difference (quotient bit 1) or restore the shifted value (bit 0).
module divide_step #(
   parameter int DIVISOR_W = 16
) (
   input  logic [DIVISOR_W:0]   prem_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W:0]   prem_o,
   output logic                 qbit_o
);

   logic [DIVISOR_W:0]   shifted_s;
   logic [DIVISOR_W+1:0] trial_s;
   logic                 prem_msb_unused;

   // The partial remainder is always below the divisor, so its top bit is
   // zero on entry; only the shifted value needs the extra bit.
   assign prem_msb_unused = prem_i[DIVISOR_W];

   // Shift, trial subtract, and choose between difference and restore
   always_comb begin
      shifted_s = {prem_i[DIVISOR_W-1:0], bit_i};
      trial_s   = {1'b0, shifted_s} - {2'b00, divisor_i};
      qbit_o    = ~trial_s[DIVISOR_W+1];
      if (qbit_o) begin
         prem_o = trial_s[DIVISOR_W:0];
      end else begin
         prem_o = shifted_s;
      end
   end

endmodule

// File: rtl/divide_restoring_param.sv
// Parametrised multi-cycle restoring divider, one quotient bit per clock.
// Optional feature macro: DIVIDE_SIGNED_EN (two's-complement operation
// selected per request by signed_op; unsigned-only when undefined).
module divide_restoring_param
   import divide_pkg::*;
#(
   parameter  int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter  int DIVISOR_W  = DEF_DIVISOR_W,
   localparam int CNT_W      = $clog2(DIVIDEND_W)
) (
   input logic                     clk,
   input logic                     rst,
   divide_restoring_param_if.slave bus
);

   localparam logic [DIVIDEND_W-1:0] DIV0_QUO = DIVIDEND_W'(div0_quotient(DIVIDEND_W));
   localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DIVIDEND_W - 1);

   div_state_t            state_q, state_d;
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;          // dividend bits out, quotient bits in
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;          // divisor magnitude
   logic [DIVISOR_W:0]    prem_q, prem_d;        // partial remainder
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic                  div0_q, div0_d;
   logic                  load_s;

   logic [DIVIDEND_W-1:0] dvd_mag_s;
   logic [DIVISOR_W-1:0]  dvs_mag_s;
   logic [DIVISOR_W:0]    prem_next_s;
   logic                  qbit_s;
   logic [DIVIDEND_W-1:0] quo_raw_s, quo_fin_s;
   logic [DIVISOR_W-1:0]  rem_raw_s, rem_fin_s;

   divide_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .prem_i    (prem_q),
      .bit_i     (dvd_q[DIVIDEND_W-1]),
      .divisor_i (dvs_q),
      .prem_o    (prem_next_s),
      .qbit_o    (qbit_s)
   );

   // Result of the step taken on the final edge, before any sign fix-up
   assign quo_raw_s = {dvd_q[DIVIDEND_W-2:0], qbit_s};
   assign rem_raw_s = prem_next_s[DIVISOR_W-1:0];

`ifdef DIVIDE_SIGNED_EN
   logic dvd_neg_s, dvs_neg_s;
   logic neg_quo_q, neg_rem_q;

   assign dvd_neg_s = bus.signed_op & bus.dividend[DIVIDEND_W-1];
   assign dvs_neg_s = bus.signed_op & bus.divisor[DIVISOR_W-1];
   // The most negative value maps onto itself, which read unsigned is the
   // correct magnitude; MIN / -1 therefore wraps back to MIN naturally.
   assign dvd_mag_s = dvd_neg_s ? (~bus.dividend + DIVIDEND_W'(1)) : bus.dividend;
   assign dvs_mag_s = dvs_neg_s ? (~bus.divisor + DIVISOR_W'(1)) : bus.divisor;
   assign quo_fin_s = neg_quo_q ? (~quo_raw_s + DIVIDEND_W'(1)) : quo_raw_s;
   assign rem_fin_s = neg_rem_q ? (~rem_raw_s + DIVISOR_W'(1)) : rem_raw_s;

   // Remember the result signs of an accepted operation for the final edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (load_s) begin
         neg_quo_q <= dvd_neg_s ^ dvs_neg_s;
         neg_rem_q <= dvd_neg_s;
      end
   end
`else
   logic signed_op_unused;

   assign signed_op_unused = bus.signed_op;
   assign dvd_mag_s        = bus.dividend;
   assign dvs_mag_s        = bus.divisor;
   assign quo_fin_s        = quo_raw_s;
   assign rem_fin_s        = rem_raw_s;
`endif

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         dvd_q       <= DIVIDEND_W'(0);
         dvs_q       <= DIVISOR_W'(0);
         prem_q      <= (DIVISOR_W + 1)'(0);
         count_q     <= CNT_W'(0);
         quotient_q  <= DIVIDEND_W'(0);
         remainder_q <= DIVISOR_W'(0);
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         div0_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         prem_q      <= prem_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         div0_q      <= div0_d;
      end
   end

   // Next-state and datapath control: accept, iterate, publish result
   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      prem_d      = prem_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      busy_d      = busy_q;
      ready_d     = ready_q;
      div0_d      = div0_q;
      load_s      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               if (bus.divisor == DIVISOR_W'(0)) begin
                  // Zero divisor completes on the accepting edge
                  quotient_d  = DIV0_QUO;
                  remainder_d = bus.dividend[DIVISOR_W-1:0];
                  div0_d      = 1'b1;
                  ready_d     = 1'b1;
                  busy_d      = 1'b0;
                  count_d     = CNT_W'(0);
                  state_d     = DONE;
               end else begin
                  load_s  = 1'b1;
                  dvd_d   = dvd_mag_s;
                  dvs_d   = dvs_mag_s;
                  prem_d  = (DIVISOR_W + 1)'(0);
                  div0_d  = 1'b0;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
                  count_d = CNT_W'(0);
                  state_d = RUN;
               end
            end else begin
               state_d = state_q;
            end
         end

         RUN: begin
            dvd_d  = quo_raw_s;
            prem_d = prem_next_s;
            if (count_q == LAST_CNT) begin
               quotient_d  = quo_fin_s;
               remainder_d = rem_fin_s;
               busy_d      = 1'b0;
               ready_d     = 1'b1;
               count_d     = CNT_W'(0);
               state_d     = DONE;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b0;
            count_d = CNT_W'(0);
         end
      endcase
   end

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.busy      = busy_q;
   assign bus.ready     = ready_q;
   assign bus.div0      = div0_q;
   assign bus.count     = count_q;

endmodule

// File: doc/divide_restoring_param.md
# divide_restoring_param

Parametrised multi-cycle restoring divider.
- Successor to the fixed 32/16 unsigned restoring divider; same start/busy/ready/count handshake and one quotient bit per cycle.
- Generalised dividend/divisor widths, explicit divide-by-zero handling, held result state, and optional compiled-in signed mode.
- Shared datapath unit behind the integer ALU's multi-cycle port.

## Interface
- DIVIDEND_W, 32, dividend/quotient width; ≥2.
- DIVISOR_W, 16, divisor/remainder width; 2 ≤ DIVISOR_W ≤ DIVIDEND_W.
- CNT_W, $clog2(DIVIDEND_W), width of count (derived, not overridden).
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled on rising edge.
- signed_op  input  1  1 = two's-complement operation (only with DIVIDE_SIGNED_EN).
- dividend  input  DIVIDEND_W  sampled with accepted start only.
- divisor  input  DIVISOR_W  sampled with accepted start only.
- quotient  output  DIVIDEND_W  registered result.
- remainder  output  DIVISOR_W  registered result.
- busy  output  1  iterations in progress.
- ready  output  1  result valid; held until next accepted start.
- div0  output  1  last accepted operation had divisor == 0; valid with ready.
- count  output  CNT_W  completed iterations of current operation.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: quotient=0, remainder=0, busy=0, ready=0, div0=0, count=0.
- Start accepted in IDLE or DONE only; ignored in RUN with no effect on state or operands.
- On accept with divisor != 0:
  - load operands to internal registers, clear partial remainder (DIVISOR_W+1 bits).
  - ready=0, busy=1, count=0, div0=0 → RUN.
- Each RUN edge performs one restoring step, MSB of dividend first:
  - shift {partial remainder, dividend} left by 1.
  - trial = partial remainder − divisor.
  - trial ≥ 0: keep trial, quotient bit 1; else restore, quotient bit 0.
  - count increments.
- The DIVIDEND_W-th step transitions → DONE: busy=0, ready=1, count=0, results written.
- On accept with divisor == 0: one cycle, no RUN.
  - → DONE: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div0=1, ready=1, busy=0.
- Outputs in DONE stay stable until the next accept; input changes in IDLE, RUN and DONE are ignored.
- Reset asserted in any state, including mid-RUN: outputs forced to reset values asynchronously; operation discarded.

## Timing
- Accept at edge E0; steps at E1..EN with N = DIVIDEND_W.
- ready rises after EN, so latency is N+1 edges from the start sample.
- Divide-by-zero: ready after E0 (latency 1).
- Back-to-back operation: start held high in DONE is accepted at the next edge; ready drops after that edge.
- count after edge Ek = k for 1 ≤ k < N, and 0 after EN.

## Configuration
- DIVIDE_SIGNED_EN defined:
  - if signed_op=1, operands are converted to magnitudes at accept and the same unsigned RUN sequence is used.
  - at the final edge, quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - MIN / −1 wraps to quotient = MIN, remainder = 0, no flag.
  - div0 result is the same as unsigned.
- DIVIDE_SIGNED_EN undefined: signed_op is ignored; all operations are unsigned; no sign logic is synthesised.

## Structure
- Package divide_pkg holds:
  - state enum div_state_t {IDLE, RUN, DONE}.
  - default width constants.
  - the divide-by-zero quotient constant function (all ones of width).
- Sub-module divide_step: one combinational restoring step (shift, trial subtract, restore, quotient bit), DIVISOR_W-parametrised. Instantiated once and reused every cycle.

## Test plan
- Default widths, 0x0002_0000 / 0xFFFF, start at E0 → ready after E32, quotient=0x00000002, remainder=0x0002, div0=0; count 1..31 then 0.
- 0xFFFF_FFFF / 0x0001 → quotient=0xFFFFFFFF, remainder=0x0000. Second start held high in DONE → new operation accepted next edge, ready drops.
- 0x1234_5678 / 0x0000 → after E0: ready=1, div0=1, quotient=0xFFFFFFFF, remainder=0x5678, busy never high.
- Start pulsed with new operands at count=10 → ignored; the original result is delivered on schedule.
- Reset asserted mid-edge-cycle at count=10 → all outputs 0 without waiting for a clock edge; next start runs a full operation correctly.
- DIVIDE_SIGNED_EN, signed_op=1:
  - −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFF.
  - 0x8000_0000 / 0xFFFF → quotient=0x80000000, remainder=0.
  - Repeat with DIVIDEND_W=8, DIVISOR_W=8: 200/7 unsigned → quotient=28, remainder=4, ready after 9 edges.
